hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and bypass controller for the 5-stage CPU. It tracks destination registers of in-flight instructions and generates the EX/DM bypass selects consumed by the source-operand muxes in EX. It detects load-use hazards and inserts one-cycle bubbles, applies control-flow flushes from EX, and freezes the pipeline on external (memory) stalls. It sits in ID, beside the decoder; all stage-register stall/flush controls originate here.

## Interface
- AW, 4, register address width (16 registers; R0 hardwired zero)
- CNT_W, 16, width of load-use stall counter

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  valid instruction present in ID
- re0 / re1  in  1  ID instruction reads port 0 / port 1
- p0_addr / p1_addr  in  AW  ID read addresses, port 0 / port 1
- dst_addr  in  AW  ID destination register
- we_ID  in  1  ID instruction writes the register file
- ld_ID  in  1  ID instruction is a load (LW)
- flow_change_EX  in  1  taken branch/jump resolved in EX
- ext_stall  in  1  memory not ready; freeze the whole pipeline
- byp0_EX, byp1_EX  out  1  EX-stage instruction takes dst_EX_DM on port 0/1
- byp0_DM, byp1_DM  out  1  EX-stage instruction takes dst_DM_WB on port 0/1
- stall_IF_ID  out  1  hold PC and IF/ID register
- stall_ID_EX, stall_EX_DM, stall_DM_WB  out  1  hold the respective stage register
- flush_IF_ID, flush_ID_EX  out  1  load bubble into the stage register on the next edge
- ld_use_cnt  out  CNT_W  saturating count of load-use bubbles inserted

## Operation
- Internal tracking, one entry per stage: ID_EX {v, addr, ld}, EX_DM {v, addr}, DM_WB {v, addr}. v = instruction writes the RF.
- match(a, e) = e.v & (a == e.addr) & (a != 0). A register address of 0 never matches.
- hazard = id_valid & ID_EX.ld & ID_EX.v & ((re0 & p0_addr==ID_EX.addr) | (re1 & p1_addr==ID_EX.addr)) & (addr != 0).
- Combinational controls:
  - stall_IF_ID = ext_stall | (hazard & ~flow_change_EX)
  - stall_ID_EX = stall_EX_DM = stall_DM_WB = ext_stall
  - flush_IF_ID = flow_change_EX & ~ext_stall
  - flush_ID_EX = (hazard | flow_change_EX) & ~ext_stall
- Edge update, only when ~ext_stall:
  - DM_WB <= EX_DM; EX_DM <= ID_EX.
  - If flush_ID_EX, ID_EX <= bubble (v=0, ld=0) and all byp flops <= 0.
  - Otherwise ID_EX <= {id_valid & we_ID, dst_addr, ld_ID}.
  - Otherwise bypx_EX <= rex & match(px_addr, ID_EX).
  - Otherwise bypx_DM <= rex & match(px_addr, EX_DM) & ~bypx_EX_next. The EX and DM selects are mutually exclusive; EX wins because it holds the newer data.
- The RF is write-through, so a writer in DM_WB during the reader's ID cycle needs no bypass from this block.
- flow_change_EX has priority over hazard. A flushed ID instruction causes no stall.
- ld_use_cnt increments on every cycle with hazard & ~flow_change_EX & ~ext_stall, and saturates at all-ones.
- During ext_stall, tracking, byp flops and the counter hold. A flush pending during ext_stall takes effect on the first cycle after ext_stall drops; flow_change_EX stays asserted because EX is frozen.

## Timing
- Reset (rst_n low, async): all tracking v/ld = 0, byp* = 0, ld_use_cnt = 0. While rst_n is low, all stall/flush outputs are forced to 0.
- byp* are registered. They are computed in the instruction's ID cycle and are valid throughout its EX cycle, aligned with src0sel_ID_EX/src1sel_ID_EX.
- Load-use costs exactly 1 bubble. Cycle n: consumer in ID, load in EX, stall_IF_ID=1, flush_ID_EX=1. Cycle n+1: consumer re-evaluates with the load in DM, so byp_DM is set. Cycle n+2: consumer in EX takes dst_DM_WB.
- Back-to-back ALU dependency: zero stall; byp_EX is asserted in the consumer's EX cycle.
- All stall/flush outputs are combinational from current inputs and state, with no extra latency.

## Test plan
- ADD R3 followed immediately by SUB reading R3 on port 1 -> byp1_EX=1 in SUB's EX cycle; no stall; byp1_DM=0.
- ADD R3, NOP, then reader of R3 on port 0 -> byp0_DM=1 in the reader's EX cycle.
- LW R5, then ADD reading R5 on port 0 -> one cycle of stall_IF_ID=1 and flush_ID_EX=1; next cycle byp0_DM=1 for ADD's EX; ld_use_cnt goes 0->1.
- Writer and reader both using R0 -> all byp stay 0 and no stall, including a LW R0 followed by a read of R0.
- Load-use hazard coincident with flow_change_EX=1 -> flush_IF_ID=flush_ID_EX=1, stall_IF_ID=0, ld_use_cnt unchanged.
- ext_stall held for 3 cycles during a pending load-use -> all stage stalls=1, flushes=0, byp/counter frozen; after release, a single bubble is inserted; rst_n pulsed mid-sequence -> all outputs 0 immediately.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and bypass controller for the 5-stage pipeline: tracks in-flight writers,
// registers EX/DM bypass selects, and drives all stage stall/flush controls.

module hazard_byp_port #(
   parameter int AW = 4
) (
   input  logic          re,
   input  logic [AW-1:0] rd_addr,
   input  logic          ex_v,
   input  logic [AW-1:0] ex_addr,
   input  logic          dm_v,
   input  logic [AW-1:0] dm_addr,
   output logic          hit_ex,
   output logic          hit_dm
);
   logic nz;

   assign nz     = (rd_addr != '0);
   assign hit_ex = re & nz & ex_v & (rd_addr == ex_addr);
   // The newer producer wins, so the older select is masked off.
   assign hit_dm = re & nz & dm_v & (rd_addr == dm_addr) & ~hit_ex;
endmodule

module hazard_ctrl #(
   parameter int AW    = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic             re0,
   input  logic             re1,
   input  logic [AW-1:0]    p0_addr,
   input  logic [AW-1:0]    p1_addr,
   input  logic [AW-1:0]    dst_addr,
   input  logic             we_ID,
   input  logic             ld_ID,
   input  logic             flow_change_EX,
   input  logic             ext_stall,
   output logic             byp0_EX,
   output logic             byp1_EX,
   output logic             byp0_DM,
   output logic             byp1_DM,
   output logic             stall_IF_ID,
   output logic             stall_ID_EX,
   output logic             stall_EX_DM,
   output logic             stall_DM_WB,
   output logic             flush_IF_ID,
   output logic             flush_ID_EX,
   output logic [CNT_W-1:0] ld_use_cnt
);
   localparam int NUM_PORTS = 2;

   typedef struct packed {
      logic          v;
      logic [AW-1:0] addr;
      logic          ld;
   } id_ex_t;

   typedef struct packed {
      logic          v;
      logic [AW-1:0] addr;
   } ex_dm_t;

   // DM_WB needs no entry: the register file is write-through.
   id_ex_t id_ex_q, id_ex_d;
   ex_dm_t ex_dm_q, ex_dm_d;

   logic [NUM_PORTS-1:0]         byp_ex_q, byp_ex_d;
   logic [NUM_PORTS-1:0]         byp_dm_q, byp_dm_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;

   logic [NUM_PORTS-1:0]         re;
   logic [NUM_PORTS-1:0][AW-1:0] rd_addr;
   logic [NUM_PORTS-1:0]         hit_ex, hit_dm;

   logic hazard, ld_use, flush_id_ex;

   assign re[0]      = re0;
   assign re[1]      = re1;
   assign rd_addr[0] = p0_addr;
   assign rd_addr[1] = p1_addr;

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
      hazard_byp_port #(.AW(AW)) u_port (
         .re      (re[g]),
         .rd_addr (rd_addr[g]),
         .ex_v    (id_ex_q.v),
         .ex_addr (id_ex_q.addr),
         .dm_v    (ex_dm_q.v),
         .dm_addr (ex_dm_q.addr),
         .hit_ex  (hit_ex[g]),
         .hit_dm  (hit_dm[g])
      );
   end

   // A hit on the ID_EX entry already folds in v and the R0 exclusion.
   assign hazard      = id_valid & id_ex_q.ld & (|hit_ex);
   assign ld_use      = hazard & ~flow_change_EX & ~ext_stall;
   assign flush_id_ex = (hazard | flow_change_EX) & ~ext_stall;

   always_comb begin
      id_ex_d  = id_ex_q;
      ex_dm_d  = ex_dm_q;
      byp_ex_d = byp_ex_q;
      byp_dm_d = byp_dm_q;
      cnt_d    = cnt_q;
      if (!ext_stall) begin
         ex_dm_d = '{v: id_ex_q.v, addr: id_ex_q.addr};
         if (flush_id_ex) begin
            id_ex_d  = '0;
            byp_ex_d = '0;
            byp_dm_d = '0;
         end else begin
            id_ex_d  = '{v: id_valid & we_ID, addr: dst_addr, ld: ld_ID};
            byp_ex_d = hit_ex;
            byp_dm_d = hit_dm;
         end
         if (ld_use && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_ex_q  <= '0;
         ex_dm_q  <= '0;
         byp_ex_q <= '0;
         byp_dm_q <= '0;
         cnt_q    <= '0;
      end else begin
         id_ex_q  <= id_ex_d;
         ex_dm_q  <= ex_dm_d;
         byp_ex_q <= byp_ex_d;
         byp_dm_q <= byp_dm_d;
         cnt_q    <= cnt_d;
      end
   end

   // Controls are gated by rst_n so nothing moves while reset is held.
   assign stall_IF_ID = rst_n & (ext_stall | (hazard & ~flow_change_EX));
   assign stall_ID_EX = rst_n & ext_stall;
   assign stall_EX_DM = rst_n & ext_stall;
   assign stall_DM_WB = rst_n & ext_stall;
   assign flush_IF_ID = rst_n & flow_change_EX & ~ext_stall;
   assign flush_ID_EX = rst_n & flush_id_ex;

   assign byp0_EX    = byp_ex_q[0];
   assign byp1_EX    = byp_ex_q[1];
   assign byp0_DM    = byp_dm_q[0];
   assign byp1_DM    = byp_dm_q[1];
   assign ld_use_cnt = cnt_q;
endmodule
